// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared sprite constants, sprite ids and width helper
package sprite_pkg;

  // Default geometry of the sprite set
  localparam int NUM_SPRITES_DEF = 9;
  localparam int ADDR_W_DEF      = 12;
  localparam int DATA_W_DEF      = 6;
  localparam int FRAMES_DEF      = 2;
  localparam int ANIM_DIV_DEF    = 8;

  // Character sprite indices as stored in the ROM bank
  typedef enum logic [3:0] {
    SPR_KNIGHT = 4'd0,
    SPR_ARCHER = 4'd1,
    SPR_MAGE   = 4'd2,
    SPR_ROGUE  = 4'd3,
    SPR_CLERIC = 4'd4,
    SPR_GOLEM  = 4'd5,
    SPR_WRAITH = 4'd6,
    SPR_DRAKE  = 4'd7,
    SPR_SLIME  = 4'd8
  } sprite_id_e;

  // Sprite shown after reset and substituted for out-of-range indices
  localparam sprite_id_e SPR_DEFAULT = SPR_KNIGHT;

  // Bit width needed to index n items, never less than one bit
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_rom_bank.sv
// rtl/sprite_rom_bank.sv - all sprite ROMs plus the sprite index mux
// Ports:
//   sprite_idx : sprite to read, out-of-range values read the default sprite
//   rom_addr   : {animation frame, pixel address}
//   pixel      : combinational pixel colour
module sprite_rom_bank
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = NUM_SPRITES_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int FRAMES      = FRAMES_DEF,
  localparam int SEL_W      = width_of(NUM_SPRITES),
  localparam int FRM_W      = width_of(FRAMES),
  localparam int ROM_AW     = ADDR_W + FRM_W
) (
  input  logic [SEL_W-1:0]  sprite_idx,
  input  logic [ROM_AW-1:0] rom_addr,
  output logic [DATA_W-1:0] pixel
);

  logic [ADDR_W-1:0] pix_addr;
  logic [FRM_W-1:0]  frm;
  logic [DATA_W-1:0] pattern;
  logic [DATA_W-1:0] bank [2**SEL_W];

  assign pix_addr = rom_addr[ADDR_W-1:0];
  assign frm      = rom_addr[ROM_AW-1:ADDR_W];

  // Artwork is a folded address pattern, offset per sprite and per frame so
  // every sprite/frame pair has distinct contents.
  assign pattern = DATA_W'(pix_addr ^ (pix_addr >> 6));

  // Unused index slots are filled with the default sprite so any index
  // beyond the sprite set reads it without extra compare logic.
  for (genvar s = 0; s < 2**SEL_W; s++) begin : g_spr
    localparam int S = (s < NUM_SPRITES) ? s : int'(SPR_DEFAULT);
    assign bank[s] = pattern + DATA_W'(S * 11) + DATA_W'(frm) * DATA_W'(23);
  end

  assign pixel = bank[sprite_idx];

endmodule

// File: rtl/sprite_fetch_unit.sv
// rtl/sprite_fetch_unit.sv - character select, animation stepping and 2-cycle pixel fetch
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   char_sel, sel_req : requested character and its capture strobe
//   frame_start       : vertical blank pulse, the only point characters switch
//   rd_en, address    : pixel read request
//   data, data_valid  : pixel result, two cycles after the request
//   active_char       : character being displayed
//   anim_frame        : current animation frame
//   bad_sel           : sticky out-of-range request flag
module sprite_fetch_unit
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = NUM_SPRITES_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int FRAMES      = FRAMES_DEF,
  parameter int ANIM_DIV    = ANIM_DIV_DEF,
  localparam int SEL_W      = width_of(NUM_SPRITES),
  localparam int FRM_W      = width_of(FRAMES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SEL_W-1:0]  char_sel,
  input  logic              sel_req,
  input  logic              frame_start,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic [SEL_W-1:0]  active_char,
  output logic [FRM_W-1:0]  anim_frame,
  output logic              bad_sel
);

  localparam int DIV_W  = width_of(ANIM_DIV);
  localparam int ROM_AW = ADDR_W + FRM_W;

  localparam logic [SEL_W:0]   SEL_LIMIT = (SEL_W + 1)'(NUM_SPRITES);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(ANIM_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(FRAMES - 1);
  localparam logic [SEL_W-1:0] SEL_RESET = SEL_W'(SPR_DEFAULT);

  logic [SEL_W-1:0] pending;
  logic             pend_flag;
  logic [DIV_W-1:0] divider;

  logic              s1_valid;
  logic [ROM_AW-1:0] s1_addr;
  logic [SEL_W-1:0]  s1_char;
  logic [DATA_W-1:0] rom_pixel;

  logic             sel_ok;
  logic             new_sel;
  logic             do_change;
  logic [SEL_W-1:0] next_char;

  always_comb begin
    sel_ok    = ({1'b0, char_sel} < SEL_LIMIT);
    new_sel   = sel_req & sel_ok;
    // A request arriving with the frame pulse beats any older pending one
    do_change = frame_start & (new_sel | pend_flag);
    next_char = new_sel ? char_sel : pending;
  end

  // Character selection and animation timing
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_char <= SEL_RESET;
      pending     <= SEL_RESET;
      pend_flag   <= 1'b0;
      divider     <= '0;
      anim_frame  <= '0;
      bad_sel     <= 1'b0;
    end else begin
      if (sel_req && !sel_ok) begin
        bad_sel <= 1'b1;
      end
      if (new_sel) begin
        pending <= char_sel;
      end
      if (do_change) begin
        // Character switch restarts the animation instead of advancing it
        active_char <= next_char;
        pend_flag   <= 1'b0;
        divider     <= '0;
        anim_frame  <= '0;
      end else begin
        if (new_sel) begin
          pend_flag <= 1'b1;
        end
        if (frame_start) begin
          if (divider == DIV_LAST) begin
            divider    <= '0;
            anim_frame <= (anim_frame == FRM_LAST) ? '0 : anim_frame + 1'b1;
          end else begin
            divider <= divider + 1'b1;
          end
        end
      end
    end
  end

  // Stage 1 captures the sprite with the address so an in-flight read is
  // unaffected by a character switch on the following edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_addr    <= '0;
      s1_char    <= SEL_RESET;
      data_valid <= 1'b0;
      data       <= '0;
    end else begin
      s1_valid   <= rd_en;
      data_valid <= s1_valid;
      if (rd_en) begin
        s1_addr <= {anim_frame, address};
        s1_char <= active_char;
      end
      if (s1_valid) begin
        data <= rom_pixel;
      end
    end
  end

  sprite_rom_bank #(
    .NUM_SPRITES(NUM_SPRITES),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .FRAMES     (FRAMES)
  ) u_rom_bank (
    .sprite_idx(s1_char),
    .rom_addr  (s1_addr),
    .pixel     (rom_pixel)
  );

endmodule

// File: tb/tb_sprite_fetch_unit.sv
// tb/tb_sprite_fetch_unit.sv - self-checking bench for sprite_fetch_unit
module tb_sprite_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  char_sel;
  logic        sel_req;
  logic        frame_start;
  logic        rd_en;
  logic [11:0] address;
  logic [5:0]  data;
  logic        data_valid;
  logic [3:0]  active_char;
  logic [0:0]  anim_frame;
  logic        bad_sel;

  int checks   = 0;
  int failures = 0;

  sprite_fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .char_sel   (char_sel),
    .sel_req    (sel_req),
    .frame_start(frame_start),
    .rd_en      (rd_en),
    .address    (address),
    .data       (data),
    .data_valid (data_valid),
    .active_char(active_char),
    .anim_frame (anim_frame),
    .bad_sel    (bad_sel)
  );

  always #5 clk = ~clk;

  // Reference model: sprite artwork and selection/animation rules
  typedef struct {
    bit       v;
    logic [5:0] d;
  } rd_t;

  rd_t        q[$];
  int         m_active, m_pending, m_div, m_anim;
  bit         m_pflag, m_bad;
  bit         exp_dv;
  logic [5:0] exp_data;

  function automatic logic [5:0] pix(input int s, input int f, input int a);
    return 6'(((a ^ (a >> 6)) + s * 11 + f * 23) % 64);
  endfunction

  task model_update;
    rd_t r;
    bit  ok;
    if (!rst_n) begin
      m_active = 0; m_pending = 0; m_pflag = 0; m_div = 0; m_anim = 0; m_bad = 0;
      q.delete();
      exp_dv = 0;
      exp_data = 6'd0;
    end else begin
      ok = sel_req && (int'(char_sel) < 9);
      if (sel_req && !ok) m_bad = 1;
      if (q.size() == 2) void'(q.pop_front());
      r.v = rd_en;
      r.d = rd_en ? pix(m_active, m_anim, int'(address)) : 6'd0;
      q.push_back(r);
      exp_dv = (q.size() == 2) && q[0].v;
      if (exp_dv) exp_data = q[0].d;
      if (frame_start && (ok || m_pflag)) begin
        m_active = ok ? int'(char_sel) : m_pending;
        m_pflag = 0; m_anim = 0; m_div = 0;
      end else begin
        if (ok) begin m_pending = int'(char_sel); m_pflag = 1; end
        if (frame_start) begin
          m_div++;
          if (m_div == 8) begin m_div = 0; m_anim = (m_anim + 1) % 2; end
        end
      end
    end
  endtask

  task step;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task test_reset;
    rst_n = 0; char_sel = 0; sel_req = 0; frame_start = 0; rd_en = 0; address = 0;
    step(); step();
    rst_n = 1;
    checks++; if (data !== 6'd0) begin failures++; $display("FAIL reset_data got=%0d exp=0", data); end
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL reset_dv got=%0d exp=0", data_valid); end
    checks++; if (active_char !== 4'd0) begin failures++; $display("FAIL reset_active got=%0d exp=0", active_char); end
    checks++; if (anim_frame !== 1'b0) begin failures++; $display("FAIL reset_anim got=%0d exp=0", anim_frame); end
    checks++; if (bad_sel !== 1'b0) begin failures++; $display("FAIL reset_bad got=%0d exp=0", bad_sel); end
  endtask

  task test_first_read;
    rd_en = 1; address = 12'h000;
    step();
    rd_en = 0;
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL first_read_early_dv got=%0d exp=0", data_valid); end
    step();
    checks++; if (data_valid !== 1'b1) begin failures++; $display("FAIL first_read_dv got=%0d exp=1", data_valid); end
    checks++; if (data !== pix(0, 0, 0)) begin failures++; $display("FAIL first_read_data got=%0d exp=%0d", data, pix(0, 0, 0)); end
    step();
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL first_read_dv_drop got=%0d exp=0", data_valid); end
    checks++; if (data !== pix(0, 0, 0)) begin failures++; $display("FAIL first_read_hold got=%0d exp=%0d", data, pix(0, 0, 0)); end
  endtask

  task test_char_select;
    sel_req = 1; char_sel = 4'd3;
    step();
    sel_req = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (active_char !== 4'd0) begin failures++; $display("FAIL sel_midframe got=%0d exp=0", active_char); end
      step();
    end
    frame_start = 1;
    step();
    frame_start = 0;
    checks++; if (active_char !== 4'd3) begin failures++; $display("FAIL sel_applied got=%0d exp=3", active_char); end
    checks++; if (anim_frame !== 1'b0) begin failures++; $display("FAIL sel_anim got=%0d exp=0", anim_frame); end
  endtask

  task test_bad_sel;
    sel_req = 1; char_sel = 4'd9;
    step();
    sel_req = 0;
    checks++; if (bad_sel !== 1'b1) begin failures++; $display("FAIL bad_set got=%0d exp=1", bad_sel); end
    frame_start = 1;
    step();
    frame_start = 0;
    checks++; if (active_char !== 4'd3) begin failures++; $display("FAIL bad_active got=%0d exp=3", active_char); end
    sel_req = 1; char_sel = 4'd1;
    step();
    sel_req = 0;
    checks++; if (bad_sel !== 1'b1) begin failures++; $display("FAIL bad_sticky got=%0d exp=1", bad_sel); end
    frame_start = 1;
    step();
    frame_start = 0;
    checks++; if (active_char !== 4'd1) begin failures++; $display("FAIL bad_then_valid got=%0d exp=1", active_char); end
  endtask

  task test_anim;
    checks++; if (bad_sel !== 1'b1) begin failures++; $display("FAIL bad_before_reset got=%0d exp=1", bad_sel); end
    rst_n = 0;
    step();
    rst_n = 1;
    checks++; if (bad_sel !== 1'b0) begin failures++; $display("FAIL bad_cleared got=%0d exp=0", bad_sel); end
    for (int p = 1; p <= 16; p++) begin
      frame_start = 1;
      step();
      frame_start = 0;
      step();
      checks++;
      if (anim_frame !== 1'(((p / 8) % 2))) begin
        failures++; $display("FAIL anim_pulse_%0d got=%0d exp=%0d", p, anim_frame, (p / 8) % 2);
      end
    end
  endtask

  task test_back_to_back;
    int nvalid;
    logic [5:0] want;
    nvalid = 0;
    sel_req = 1; char_sel = 4'd5;
    step();
    sel_req = 0;
    for (int i = 0; i < 7; i++) begin
      rd_en = (i < 5); address = 12'(i); frame_start = (i == 2);
      step();
      if (data_valid === 1'b1) nvalid++;
      if (i >= 1 && i <= 5) begin
        // Reads 0..2 sampled the old character, 3..4 the new one
        want = (i - 1 < 3) ? pix(0, 0, i - 1) : pix(5, 0, i - 1);
        checks++; if (data_valid !== 1'b1) begin failures++; $display("FAIL b2b_dv_%0d got=%0d exp=1", i - 1, data_valid); end
        checks++; if (data !== want) begin failures++; $display("FAIL b2b_data_%0d got=%0d exp=%0d", i - 1, data, want); end
      end
    end
    rd_en = 0; frame_start = 0;
    checks++; if (nvalid != 5) begin failures++; $display("FAIL b2b_count got=%0d exp=5", nvalid); end
    checks++; if (active_char !== 4'd5) begin failures++; $display("FAIL b2b_active got=%0d exp=5", active_char); end
  endtask

  task test_reset_flush;
    rd_en = 1; address = 12'h0a5;
    step();
    rd_en = 0; rst_n = 0;
    step();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL flush_dv_%0d got=%0d exp=0", i, data_valid); end
      checks++; if (data !== 6'd0) begin failures++; $display("FAIL flush_data_%0d got=%0d exp=0", i, data); end
      step();
    end
  endtask

  task test_random;
    for (int i = 0; i < 400; i++) begin
      rst_n       = ($urandom_range(0, 99) != 0);
      sel_req     = ($urandom_range(0, 9) == 0);
      char_sel    = 4'($urandom_range(0, 15));
      frame_start = ($urandom_range(0, 5) == 0);
      rd_en       = ($urandom_range(0, 1) == 1);
      address     = 12'($urandom);
      step();
      checks++; if (data_valid !== exp_dv) begin failures++; $display("FAIL rand_dv_%0d got=%0d exp=%0d", i, data_valid, exp_dv); end
      checks++; if (data !== exp_data) begin failures++; $display("FAIL rand_data_%0d got=%0d exp=%0d", i, data, exp_data); end
      checks++; if (active_char !== 4'(m_active)) begin failures++; $display("FAIL rand_active_%0d got=%0d exp=%0d", i, active_char, m_active); end
      checks++; if (anim_frame !== 1'(m_anim)) begin failures++; $display("FAIL rand_anim_%0d got=%0d exp=%0d", i, anim_frame, m_anim); end
      checks++; if (bad_sel !== m_bad) begin failures++; $display("FAIL rand_bad_%0d got=%0d exp=%0d", i, bad_sel, m_bad); end
    end
    rst_n = 1; sel_req = 0; frame_start = 0; rd_en = 0;
  endtask

  initial begin
    test_reset();
    test_first_read();
    test_char_select();
    test_bad_sel();
    test_anim();
    test_back_to_back();
    test_reset_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_fetch_unit.md
SPRITE_FETCH_UNIT -- requirements
Module: sprite_fetch_unit

Interface
REQ-001 The module SHALL have parameter NUM_SPRITES, default 9: number of selectable character sprites.
REQ-002 The module SHALL have parameter ADDR_W, default 12: pixel address width within one sprite frame.
REQ-003 The module SHALL have parameter DATA_W, default 6: pixel colour width.
REQ-004 The module SHALL have parameter FRAMES, default 2 (power of two): animation frames per sprite.
REQ-005 The module SHALL have parameter ANIM_DIV, default 8: frame_start pulses per animation step.
REQ-006 The module SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge; one clock, no other clock domains.
REQ-007 The module SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-008 The module SHALL have port char_sel, input, SEL_W = clog2(NUM_SPRITES) bits: requested character.
REQ-009 The module SHALL have port sel_req, input, 1 bit: one-cycle strobe that captures char_sel.
REQ-010 The module SHALL have port frame_start, input, 1 bit: one-cycle pulse at vertical blank.
REQ-011 The module SHALL have port rd_en, input, 1 bit: pixel read request.
REQ-012 The module SHALL have port address, input, ADDR_W bits: pixel address.
REQ-013 The module SHALL have port data, output, DATA_W bits: pixel colour.
REQ-014 The module SHALL have port data_valid, output, 1 bit: data corresponds to a read issued 2 cycles earlier.
REQ-015 The module SHALL have port active_char, output, SEL_W bits: character currently being displayed.
REQ-016 The module SHALL have port anim_frame, output, clog2(FRAMES) bits: current animation frame.
REQ-017 The module SHALL have port bad_sel, output, 1 bit: sticky flag set by an out-of-range request.

Function
REQ-018 On sel_req with char_sel < NUM_SPRITES, the unit SHALL store char_sel as pending and set pend_flag.
REQ-019 On sel_req with char_sel >= NUM_SPRITES, the unit SHALL ignore the request, leave pending unchanged and set bad_sel.
REQ-020 On frame_start with pend_flag set, the unit SHALL copy pending to active_char, clear pend_flag and reset anim_frame and the divider to 0.
REQ-021 When sel_req and frame_start coincide, the unit SHALL apply the new valid char_sel at that frame_start, with the new request winning over any older pending value.
REQ-022 active_char SHALL change only on frame_start, never mid-frame.
REQ-023 The divider SHALL count frame_start pulses from 0 to ANIM_DIV-1; at the terminal count it SHALL wrap to 0 and advance anim_frame by one.
REQ-024 anim_frame SHALL wrap from FRAMES-1 to 0.
REQ-025 A character change SHALL take precedence over an animation advance on the same frame_start.
REQ-026 Read pipeline stage 1 SHALL register rd_en and the ROM address {anim_frame, address}.
REQ-027 Read pipeline stage 2 SHALL register the ROM output selected by active_char into data and assert data_valid; latency is exactly 2 cycles and throughput is 1 read per cycle.
REQ-028 When data_valid is low, data SHALL hold its previous value.
REQ-029 A read already in flight when active_char changes SHALL complete using the sprite sampled at stage 1.

Reset
REQ-030 While rst_n is low at a clock edge, the unit SHALL drive data=0, data_valid=0, active_char=0, anim_frame=0, divider=0, pend_flag=0, pending=0 and bad_sel=0.
REQ-031 A reset asserted mid-read SHALL flush both pipeline stages, so that no data_valid pulse appears after reset for reads issued before it.
REQ-032 bad_sel SHALL clear only on reset.

Structure
REQ-033 NUM_SPRITES, the default widths and the sprite index constants SHALL live in the shared sprite constants package/include.
REQ-034 The unit SHALL instantiate one sub-module, sprite_rom_bank, holding all sprite ROMs plus the index mux, with a combinational read of width ADDR_W+clog2(FRAMES).
REQ-035 Out-of-range indices inside sprite_rom_bank SHALL return sprite 0.

Verification
REQ-036 Reset release, then rd_en=1 with address=0x000 at cycle 0 -> data_valid=1 at cycle 2 with data equal to sprite 0, frame 0, pixel 0.
REQ-037 sel_req with char_sel=3 mid-frame -> active_char stays 0 until the next frame_start, then becomes 3 and anim_frame becomes 0.
REQ-038 sel_req with char_sel=9 (NUM_SPRITES=9) -> bad_sel=1, active_char unchanged; bad_sel stays 1 until rst_n=0.
REQ-039 16 frame_start pulses with ANIM_DIV=8 and FRAMES=2 -> anim_frame goes 0 to 1 after the 8th pulse and back to 0 after the 16th.
REQ-040 Back-to-back reads at addresses 0..4 with a char change at cycle 2 -> 5 consecutive valid outputs, each from the sprite active at its stage-1 cycle.
REQ-041 rst_n=0 in the cycle after a read issue -> data_valid stays 0 and data=0.
